pq_deq_reader: RTL and testbench

- Read-side engine for the register-array priority queue.
- Pops the highest-priority key-value item from the PQ whenever local space exists, and buffers it in a small FIFO.
- Presents items to a downstream consumer over a valid/ready stream.
- Sits between the PQ's dequeue port and any sink (sorter output, scheduler, test monitor), decoupling PQ busy timing from consumer back-pressure.

---
 rtl/pq_pkg.sv | 28 ++
 rtl/kv_fifo.sv | 60 ++++++
 rtl/pq_deq_reader.sv | 104 ++++++++++
 tb/tb_pq_deq_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types for the register-array priority queue and its read-side engine.
package pq_pkg;

  localparam int unsigned KEY_W = 16;
  localparam int unsigned VAL_W = 16;

  localparam logic [KEY_W-1:0] KEY0 = '0;
  localparam logic [VAL_W-1:0] VAL0 = '0;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SETTLE
  } rd_state_t;

  function automatic kv_t kv_null();
    kv_t kv;
    kv.key = KEY0;
    kv.val = VAL0;
    return kv;
  endfunction

endpackage

// File: rtl/kv_fifo.sv
// DEPTH-entry key/value FIFO; storage is cleared to the null item on reset.
module kv_fifo
  import pq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  kv_t                    wr_kv_i,
  input  logic                   rd_en_i,
  output kv_t                    rd_kv_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  kv_t              mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_wr  = wr_en_i && (cnt_q != CNT_W'(DEPTH));
    do_rd  = rd_en_i && (cnt_q != '0);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    if (do_wr) wptr_d = wptr_q + PTR_W'(1);
    if (do_rd) rptr_d = rptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= kv_null();
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_wr) mem_q[wptr_q] <= wr_kv_i;
    end
  end

  assign rd_kv_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/pq_deq_reader.sv
// Pops PQ items into a local FIFO while space exists and streams them out.
// Optional PQ_RD_STATS_EN adds saturating pop_total / stall_cycles counters.
module pq_deq_reader
  import pq_pkg::kv_t, pq_pkg::rd_state_t;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   pq_empty,
  input  logic                   pq_busy,
  input  kv_t                    pq_kvo,
  output logic                   pq_deq,
  output logic                   out_valid,
  input  logic                   out_ready,
  output kv_t                    out_kv,
  output logic [$clog2(DEPTH):0] count
`ifdef PQ_RD_STATS_EN
  ,
  output logic [31:0]            pop_total,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  rd_state_t        state_q, state_d;
  logic [1:0]       settle_q, settle_d;
  logic             inflight, space, start, fifo_rd;
  logic [CNT_W-1:0] fifo_count;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pq_deq   = 1'b0;
    inflight = (state_q == pq_pkg::POP);
    space    = (32'(fifo_count) + 32'(inflight)) < DEPTH;
    start    = en && !pq_empty && !pq_busy && space;
    case (state_q)
      pq_pkg::IDLE: begin
        if (start) state_d = pq_pkg::POP;
      end
      pq_pkg::POP: begin
        pq_deq   = 1'b1;
        settle_d = '0;
        state_d  = pq_pkg::SETTLE;
      end
      pq_pkg::SETTLE: begin
        // Hold off for SETTLE cycles, then also wait out any PQ busy period
        if (settle_q < 2'(SETTLE - 1)) settle_d = settle_q + 2'd1;
        else if (!pq_busy)             state_d  = pq_pkg::IDLE;
      end
      default: state_d = pq_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= pq_pkg::IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  assign out_valid = (fifo_count != '0);
  assign fifo_rd   = out_valid && out_ready;
  assign count     = fifo_count;

  kv_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (pq_deq),
    .wr_kv_i (pq_kvo),
    .rd_en_i (fifo_rd),
    .rd_kv_o (out_kv),
    .count_o (fifo_count)
  );

`ifdef PQ_RD_STATS_EN
  logic [31:0] pop_total_q, stall_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_total_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (pq_deq && (pop_total_q != '1))
        pop_total_q <= pop_total_q + 32'd1;
      if (out_valid && !out_ready && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign pop_total    = pop_total_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pq_deq_reader.sv
// Scoreboard bench for pq_deq_reader: a PQ model feeds items, a monitor checks output order.
module tb_pq_deq_reader;
  import pq_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   en;
  logic                   pq_empty;
  logic                   pq_busy;
  kv_t                    pq_kvo;
  logic                   pq_deq;
  logic                   out_valid;
  logic                   out_ready;
  kv_t                    out_kv;
  logic [$clog2(DEPTH):0] count;
`ifdef PQ_RD_STATS_EN
  logic [31:0]            pop_total;
  logic [31:0]            stall_cycles;
`endif

  int   tests_run  = 0;
  int   fails      = 0;
  int   deq_cnt    = 0;
  logic hold_empty = 1'b0;
  logic prev_deq   = 1'b0;
  kv_t  exp_q[$];
  kv_t  src_q[$];

  pq_deq_reader #(
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pq_empty     (pq_empty),
    .pq_busy      (pq_busy),
    .pq_kvo       (pq_kvo),
    .pq_deq       (pq_deq),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_kv       (out_kv),
    .count        (count)
`ifdef PQ_RD_STATS_EN
    ,
    .pop_total    (pop_total),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive_pq();
    pq_empty = hold_empty || (src_q.size() == 0);
    pq_kvo   = (src_q.size() != 0) ? src_q[0] : kv_null();
  endtask

  task automatic push_src(input int k, input int v);
    kv_t kv;
    kv.key = KEY_W'(k);
    kv.val = VAL_W'(v);
    src_q.push_back(kv);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // PQ model plus scoreboard: expected items are the ones the model presented on each deq
  always begin : monitor
    logic deq_now;
    kv_t  e;
    @(negedge clk);
    deq_now = pq_deq && rst_n;
    if (rst_n) begin
      if (pq_deq) begin
        exp_q.push_back(pq_kvo);
        deq_cnt++;
        tests_run++;
        if (prev_deq) begin
          fails++;
          $display("FAIL deq_consecutive: pq_deq high on two cycles, got 1 expected 0");
        end
        tests_run++;
        if (32'(count) >= DEPTH) begin
          fails++;
          $display("FAIL deq_when_full: count=%0d during pop, required < %0d", count, DEPTH);
        end
      end
      prev_deq = pq_deq;
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow: got item %h, expected none", out_kv);
        end else begin
          e = exp_q.pop_front();
          if (out_kv !== e) begin
            fails++;
            $display("FAIL sb_order: got %h expected %h", out_kv, e);
          end
        end
      end
    end else begin
      prev_deq = 1'b0;
    end
    @(posedge clk);
    #1;
    if (deq_now && (src_q.size() != 0)) void'(src_q.pop_front());
    drive_pq();
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; pq_busy = 1'b0; hold_empty = 1'b0;
    drive_pq();
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (pq_deq !== 1'b0) begin fails++; $display("FAIL reset_deq: got %b expected 0", pq_deq); end
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests_run++;
    if (out_kv !== kv_null()) begin fails++; $display("FAIL reset_kv: got %h expected %h", out_kv, kv_null()); end
  endtask

  task automatic test_single_pop();
    int   d0;
    logic seen;
    kv_t  want;
    want.key = KEY_W'(5);
    want.val = VAL_W'(9);
    cyc(1);
    d0 = deq_cnt;
    out_ready = 1'b0; en = 1'b1;
    push_src(5, 9);
    drive_pq();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pq_deq) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin fails++; $display("FAIL single_timeout: pq_deq got 0 expected 1 within 20 cycles"); end
    if (seen) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      tests_run++;
      if (out_kv !== want) begin fails++; $display("FAIL single_kv: got %h expected %h", out_kv, want); end
      tests_run++;
      if (count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", count); end
    end
    cyc(8);
    tests_run++;
    if (deq_cnt - d0 != 1) begin fails++; $display("FAIL single_pulses: got %0d expected 1", deq_cnt - d0); end
    out_ready = 1'b1;
    cyc(2);
    out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (count !== '0) begin fails++; $display("FAIL single_drain: count got %0d expected 0", count); end
  endtask

  task automatic test_fill_drain();
    int d0;
    cyc(1);
    d0 = deq_cnt;
    out_ready = 1'b0; en = 1'b1;
    for (int k = 1; k <= 8; k++) push_src(k, k + 100);
    drive_pq();
    cyc(30);
    tests_run++;
    if (deq_cnt - d0 != int'(DEPTH)) begin fails++; $display("FAIL fill_pulses: got %0d expected %0d", deq_cnt - d0, DEPTH); end
    tests_run++;
    if (count !== 3'(DEPTH)) begin fails++; $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); end
    out_ready = 1'b1;
    cyc(40);
    tests_run++;
    if (deq_cnt - d0 != 8) begin fails++; $display("FAIL drain_pulses: got %0d expected 8", deq_cnt - d0); end
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL drain_left: %0d items undelivered, expected 0", exp_q.size()); end
    tests_run++;
    if (count !== '0) begin fails++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_busy_empty();
    int d0;
    cyc(1);
    d0 = deq_cnt;
    out_ready = 1'b1; en = 1'b1; pq_busy = 1'b1;
    push_src(20, 1);
    push_src(21, 2);
    drive_pq();
    cyc(5);
    tests_run++;
    if (deq_cnt != d0) begin fails++; $display("FAIL busy_gate: pulses got %0d expected 0", deq_cnt - d0); end
    pq_busy = 1'b0; hold_empty = 1'b1;
    drive_pq();
    cyc(5);
    tests_run++;
    if (deq_cnt != d0) begin fails++; $display("FAIL empty_gate: pulses got %0d expected 0", deq_cnt - d0); end
    hold_empty = 1'b0;
    drive_pq();
    cyc(15);
    tests_run++;
    if (deq_cnt - d0 != 2) begin fails++; $display("FAIL gate_release: pulses got %0d expected 2", deq_cnt - d0); end
  endtask

  task automatic test_enable();
    int   d0;
    logic seen;
    cyc(1);
    d0 = deq_cnt;
    out_ready = 1'b0; en = 1'b1;
    push_src(40, 7);
    push_src(41, 8);
    push_src(42, 9);
    drive_pq();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pq_deq) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin fails++; $display("FAIL enable_timeout: pq_deq got 0 expected 1 within 20 cycles"); end
    cyc(1);
    en = 1'b0;
    cyc(10);
    tests_run++;
    if (deq_cnt - d0 != 1) begin fails++; $display("FAIL enable_hold: pulses got %0d expected 1", deq_cnt - d0); end
    tests_run++;
    if (count !== 3'd1) begin fails++; $display("FAIL enable_count: got %0d expected 1", count); end
    en = 1'b1; out_ready = 1'b1;
    cyc(20);
    tests_run++;
    if (deq_cnt - d0 != 3) begin fails++; $display("FAIL enable_resume: pulses got %0d expected 3", deq_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int last;
    int n;
    cyc(1);
    out_ready = 1'b1; en = 1'b1;
    for (int k = 60; k < 64; k++) push_src(k, k);
    drive_pq();
    last = -1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pq_deq) begin
        n++;
        if (last >= 0) begin
          tests_run++;
          if (i - last != 2 + int'(SETTLE)) begin
            fails++;
            $display("FAIL b2b_interval: got %0d cycles expected %0d", i - last, 2 + SETTLE);
          end
        end
        last = i;
      end
    end
    tests_run++;
    if (n != 4) begin fails++; $display("FAIL b2b_pulses: got %0d expected 4", n); end
  endtask

  task automatic test_async_reset();
    cyc(1);
    out_ready = 1'b0; en = 1'b1;
    push_src(80, 1);
    push_src(81, 2);
    push_src(82, 3);
    drive_pq();
    cyc(15);
    tests_run++;
    if (count !== 3'd3) begin fails++; $display("FAIL areset_pre: count got %0d expected 3", count); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (count !== '0) begin fails++; $display("FAIL areset_count: got %0d expected 0", count); end
    tests_run++;
    if (pq_deq !== 1'b0) begin fails++; $display("FAIL areset_deq: got %b expected 0", pq_deq); end
    exp_q.delete();
    src_q.delete();
    drive_pq();
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_after: out_valid got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_pop();
    test_fill_drain();
    test_busy_empty();
    test_enable();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
